// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared state encoding, default parameters and jump-target helper for the fetch stage.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        SKID    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INCR_DEF  = 32'd4;

    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4, input logic [25:0] index);
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_adder.sv
// instruction_fetch_adder: plain modulo-2^W adder used for the sequential pc increment.
module instruction_fetch_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch pc, imem valid/ready requests, IF/ID register with one-entry skid and redirect handling.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_INCR  = PC_INCR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        redirect;

    instruction_fetch_adder #(.W(32)) u_pc_adder (
        .a_i  (pc_q),
        .b_i  (PC_INCR),
        .sum_o(pc_plus4)
    );

    assign redirect = jump | branch_taken;
    assign target   = jump ? jump_target(pc4_q, jump_index) : (branch_target & ~32'h3);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        pc4_d         = pc4_q;
        skid_instr_d  = skid_instr_q;
        skid_pc4_d    = skid_pc4_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = target;
                    end else begin
                        redirect_pc_d = target;
                        state_d       = DISCARD;
                    end
                end else if (imem_ready && stall && valid_q) begin
                    skid_instr_d = imem_rdata;
                    skid_pc4_d   = pc_plus4;
                    pc_d         = pc_plus4;
                    state_d      = SKID;
                end else if (imem_ready) begin
                    valid_d = 1'b1;
                    instr_d = imem_rdata;
                    pc4_d   = pc_plus4;
                    pc_d    = pc_plus4;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            SKID: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!stall) begin
                    valid_d = 1'b1;
                    instr_d = skid_instr_q;
                    pc4_d   = skid_pc4_q;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                // The stale request must still complete before the new address can be issued.
                if (redirect) begin
                    valid_d       = 1'b0;
                    redirect_pc_d = target;
                    if (imem_ready) begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
                end else if (imem_ready) begin
                    pc_d    = redirect_pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            valid_q       <= 1'b0;
            instr_q       <= '0;
            pc4_q         <= '0;
            skid_instr_q  <= '0;
            skid_pc4_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            pc4_q         <= pc4_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc4_q    <= skid_pc4_d;
        end
    end

    assign imem_req       = !rst && (state_q != SKID);
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage sitting between the program counter and decode. Owns the fetch PC and issues requests to instruction memory over a valid/ready handshake. Selects the next PC (sequential, branch, jump) and fills a one-entry IF/ID output register, with a one-entry skid buffer for decode stalls. Redirects abandon stale fetches without violating the memory handshake.

Parameters:
RESET_PC, 32'h00000000, fetch address loaded on reset
PC_INCR, 4, sequential increment in bytes

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  decode cannot accept a new instruction this cycle
branch_taken  in  1  redirect to branch_target (from EX)
branch_target  in  32  branch destination
jump  in  1  redirect to jump target (from ID)
jump_index  in  26  J-type index field
imem_req  out  1  request valid
imem_addr  out  32  request address, word-aligned
imem_ready  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word
pc  out  32  address of current/next fetch
if_id_valid  out  1  IF/ID register holds a live instruction
if_id_instr  out  32  fetched instruction
if_id_pc_plus4  out  32  fetch address + PC_INCR

Behaviour:
- Reset (async, active-high): pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=0, if_id_pc_plus4=0, skid cleared. imem_req forced to 0 while rst=1. A request in flight at reset is abandoned; memory tolerates this.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - SKID: imem_req=0; buffered instruction held.
  - DISCARD: imem_req=1, imem_addr=pc (stale); response is dropped.
- Handshake: once imem_req=1, imem_addr stays stable until the imem_ready cycle. Zero-wait memory (ready in the same cycle as req) gives 1 instruction/cycle.
- Redirect: redirect = jump | branch_taken.
  - Target: jump has priority, target = {if_id_pc_plus4[31:28], jump_index, 2'b00}; otherwise branch_target.
  - Every redirect clears if_id_valid in the next cycle. Flush beats stall.
- FETCH with no redirect:
  - ready & (!stall | !if_id_valid): if_id <= {1, imem_rdata, pc+4}; pc <= pc+4.
  - ready & stall & if_id_valid: skid <= {imem_rdata, pc+4}; pc <= pc+4; go to SKID.
  - !ready & !stall: if_id_valid <= 0 (bubble).
  - !ready & stall: hold.
- FETCH with redirect:
  - ready in the same cycle: data dropped, pc <= target, stay in FETCH.
  - !ready: latch target in redirect_pc, go to DISCARD.
- SKID:
  - stall=0: if_id <= skid, go to FETCH.
  - redirect: drop skid, pc <= target, go to FETCH.
- DISCARD:
  - On ready: drop data, pc <= redirect_pc, go to FETCH.
  - Redirect while in DISCARD: redirect_pc <= newest target (latest wins). If it coincides with ready, pc <= newest target.
- PC arithmetic: modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0. Bits [1:0] of any target are ignored and forced to 0.
- pc output = pc register (in DISCARD it shows the stale address until ready).

Decomposition:
- Shared package holds:
  - state encoding FETCH=2'd0, SKID=2'd1, DISCARD=2'd2
  - RESET_PC and PC_INCR defaults
  - the jump-target concatenation as a function
- pc+4 uses one instance of the existing adder module (PC_INCR constant operand). No other sub-module.

Test Plan:
- Zero-wait sequential: reset, then ready held 1, rdata=addr-derived → imem_addr 0,4,8,C on consecutive cycles; if_id_pc_plus4 4,8,C,10; if_id_valid=1 from the first ready cycle.
- Wait states: ready every 3rd cycle → imem_addr held stable between readys; if_id_valid pulses 1 for one cycle per response when stall=0.
- Stall into skid: if_id_valid=1, stall=1, ready with rdata=32'hDEADBEEF at pc=8 → state SKID, imem_req=0, if_id unchanged. Release stall → if_id_instr=DEADBEEF, if_id_pc_plus4=C, pc=C.
- Branch during wait: req pending at addr 10, branch_taken=1 with target 40, ready two cycles later → imem_addr stays 10 until ready; that data is never latched; next request at 40; if_id_valid=0 until the 40 response.
- Jump priority: jump=1, jump_index=26'h0000010, if_id_pc_plus4=32'h10000004, branch_taken=1 with target 80, same cycle → next fetch at 32'h10000040.
- Async reset mid-DISCARD: assert rst between edges → imem_req=0 immediately, if_id_valid=0. After release, first imem_addr=RESET_PC.
